// File: rtl/conv_window_gen.sv
// Streaming KR x KC sliding-window generator with runtime frame size and stride.
// Optional feature macro: CONV_WINDOW_POS_EN adds out_row/out_col window coordinates.
module conv_window_gen #(
  parameter int DATA_WIDTH         = 8,
  parameter int CHANNELS           = 1,
  parameter int MAX_COLUMNS        = 2000,
  parameter int MAX_ROWS           = 2000,
  parameter int KERNEL_ROW_SIZE    = 3,
  parameter int KERNEL_COLUMN_SIZE = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [$clog2(MAX_COLUMNS+1)-1:0]       frame_column_size,
  input  logic [$clog2(MAX_ROWS+1)-1:0]          frame_row_size,
  input  logic [1:0]                             stride,
  input  logic [DATA_WIDTH*CHANNELS-1:0]         in_point,
  input  logic                                   valid_in,
  output logic                                   ready_in,
  output logic [DATA_WIDTH*CHANNELS*KERNEL_ROW_SIZE*KERNEL_COLUMN_SIZE-1:0] out_matrix,
  output logic                                   valid_out,
  input  logic                                   ready_out,
  output logic                                   frame_done
`ifdef CONV_WINDOW_POS_EN
  ,
  output logic [$clog2(MAX_ROWS)-1:0]            out_row,
  output logic [$clog2(MAX_COLUMNS)-1:0]         out_col
`endif
);

  localparam int KR  = KERNEL_ROW_SIZE;
  localparam int KC  = KERNEL_COLUMN_SIZE;
  localparam int PIX = DATA_WIDTH * CHANNELS;
  localparam int CW  = $clog2(MAX_COLUMNS + 1);
  localparam int RW  = $clog2(MAX_ROWS + 1);
  localparam int AW  = $clog2(MAX_COLUMNS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state;
  logic [CW-1:0]   col, w_q, cur_w;
  logic [RW-1:0]   row, h_q, cur_h;
  logic [1:0]      s_q, cur_s, col_phase, row_phase;
  logic            accept, col_last, row_last, hit;
  logic [AW-1:0]   addr;

  logic [PIX-1:0]  line_buf [KR-1][MAX_COLUMNS];
  logic [PIX-1:0]  win      [KR][KC];
  logic [PIX-1:0]  win_next [KR][KC];
  logic [PIX-1:0]  col_vec  [KR];
  logic [PIX*KR*KC-1:0] win_flat;

  assign ready_in = !valid_out || ready_out;
  assign accept   = valid_in && ready_in;
  assign addr     = col[AW-1:0];

  // The first pixel of a frame uses the live configuration; later pixels use the latched copy.
  always_comb begin
    if (state == IDLE) begin
      cur_w = (frame_column_size == '0) ? CW'(1) : frame_column_size;
      cur_h = (frame_row_size == '0) ? RW'(1) : frame_row_size;
      cur_s = (stride == 2'd0) ? 2'd1 : stride;
    end else begin
      cur_w = w_q;
      cur_h = h_q;
      cur_s = s_q;
    end
    col_last = (col == cur_w - CW'(1));
    row_last = (row == cur_h - RW'(1));
    hit = (row >= RW'(KR - 1)) && (col >= CW'(KC - 1)) &&
          (row_phase == 2'd0) && (col_phase == 2'd0);
  end

  always_comb begin
    for (int i = 0; i < KR - 1; i++) col_vec[i] = line_buf[i][addr];
    col_vec[KR-1] = in_point;
    for (int i = 0; i < KR; i++) begin
      for (int j = 0; j < KC - 1; j++) win_next[i][j] = win[i][j+1];
      win_next[i][KC-1] = col_vec[i];
    end
    win_flat = '0;
    for (int i = 0; i < KR; i++)
      for (int j = 0; j < KC; j++)
        win_flat[PIX*(i*KC+j) +: PIX] = win_next[i][j];
  end

  // Storage is never cleared: windows only fire once every contributing entry is from this frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < KR - 2; i++) line_buf[i][addr] <= line_buf[i+1][addr];
      line_buf[KR-2][addr] <= in_point;
      win <= win_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      s_q        <= '0;
      col_phase  <= '0;
      row_phase  <= '0;
      valid_out  <= 1'b0;
      out_matrix <= '0;
      frame_done <= 1'b0;
`ifdef CONV_WINDOW_POS_EN
      out_row    <= '0;
      out_col    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (valid_out && ready_out) valid_out <= 1'b0;
      if (accept) begin
        if (state == IDLE) begin
          w_q <= cur_w;
          h_q <= cur_h;
          s_q <= cur_s;
        end
        state <= ACTIVE;
        if (hit) begin
          valid_out  <= 1'b1;
          out_matrix <= win_flat;
`ifdef CONV_WINDOW_POS_EN
          out_row    <= ($clog2(MAX_ROWS))'(row - RW'(KR - 1));
          out_col    <= ($clog2(MAX_COLUMNS))'(col - CW'(KC - 1));
`endif
        end
        // Phase counters replace the stride modulo; they restart at every row and frame start.
        if (col_last) begin
          col       <= '0;
          col_phase <= 2'd0;
          if (row_last) begin
            row        <= '0;
            row_phase  <= 2'd0;
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            row <= row + RW'(1);
            if (row >= RW'(KR - 1))
              row_phase <= (row_phase == cur_s - 2'd1) ? 2'd0 : row_phase + 2'd1;
          end
        end else begin
          col <= col + CW'(1);
          if (col >= CW'(KC - 1))
            col_phase <= (col_phase == cur_s - 2'd1) ? 2'd0 : col_phase + 2'd1;
        end
      end
    end
  end

endmodule
